// File: rtl/pcs_8b10b_pkg.sv
// Shared 8b/10b constants, PIPE width encodings and small helpers for the PCS RX path.
package pcs_8b10b_pkg;

    localparam logic [9:0] K28_5_RDN = 10'h0FA;
    localparam logic [9:0] K28_5_RDP = 10'h305;

    localparam logic [7:0] K28_5_BYTE = 8'hBC;
    localparam logic [7:0] EDB_BYTE   = 8'hFE;

    localparam logic [2:0] ST_OK       = 3'b000;
    localparam logic [2:0] ST_DEC_ERR  = 3'b100;
    localparam logic [2:0] ST_DISP_ERR = 3'b111;

    localparam logic [5:0] DBW_8  = 6'd8;
    localparam logic [5:0] DBW_16 = 6'd16;
    localparam logic [5:0] DBW_32 = 6'd32;

    typedef enum logic {RD_NEG, RD_POS} rd_t;

    typedef enum logic [1:0] {IMB_ZERO, IMB_POS, IMB_NEG} imb_t;

    // Unknown widths fall back to a single lane.
    function automatic logic [1:0] lanes_m1(input logic [5:0] dbw);
        case (dbw)
            DBW_16:  return 2'd1;
            DBW_32:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] status_merge(input logic [2:0] a, input logic [2:0] b);
        if (a == ST_DEC_ERR || b == ST_DEC_ERR)
            return ST_DEC_ERR;
        if (a == ST_DISP_ERR || b == ST_DISP_ERR)
            return ST_DISP_ERR;
        return ST_OK;
    endfunction

endpackage

// File: rtl/pcs_8b10b_dec_core.sv
// Combinational 8b/10b symbol decoder: 5b/6b and 3b/4b lookup, K detection and sub-block imbalance.
module pcs_8b10b_dec_core
    import pcs_8b10b_pkg::*;
(
    input  logic [9:0] sym_i,
    output logic [7:0] byte_o,
    output logic       k_o,
    output logic       code_err_o,
    output imb_t       imb6_o,
    output imb_t       imb4_o
);

    logic [5:0] abcdei;
    logic [3:0] fghj;
    logic [3:0] fghj_k;
    logic [4:0] x;
    logic [2:0] y_d;
    logic [2:0] y_k;
    logic       v6;
    logic       v4d;
    logic       v4k;
    logic       is_k28;
    logic       is_kx7;

    always_comb begin
        abcdei = sym_i[9:4];
        fghj   = sym_i[3:0];
        x      = 5'd0;
        v6     = 1'b1;
        is_k28 = 1'b0;
        case (abcdei)
            6'b100111, 6'b011000: x = 5'd0;
            6'b011101, 6'b100010: x = 5'd1;
            6'b101101, 6'b010010: x = 5'd2;
            6'b110001:            x = 5'd3;
            6'b110101, 6'b001010: x = 5'd4;
            6'b101001:            x = 5'd5;
            6'b011001:            x = 5'd6;
            6'b111000, 6'b000111: x = 5'd7;
            6'b111001, 6'b000110: x = 5'd8;
            6'b100101:            x = 5'd9;
            6'b010101:            x = 5'd10;
            6'b110100:            x = 5'd11;
            6'b001101:            x = 5'd12;
            6'b101100:            x = 5'd13;
            6'b011100:            x = 5'd14;
            6'b010111, 6'b101000: x = 5'd15;
            6'b011011, 6'b100100: x = 5'd16;
            6'b100011:            x = 5'd17;
            6'b010011:            x = 5'd18;
            6'b110010:            x = 5'd19;
            6'b001011:            x = 5'd20;
            6'b101010:            x = 5'd21;
            6'b011010:            x = 5'd22;
            6'b111010, 6'b000101: x = 5'd23;
            6'b110011, 6'b001100: x = 5'd24;
            6'b100110:            x = 5'd25;
            6'b010110:            x = 5'd26;
            6'b110110, 6'b001001: x = 5'd27;
            6'b001110:            x = 5'd28;
            6'b101110, 6'b010001: x = 5'd29;
            6'b011110, 6'b100001: x = 5'd30;
            6'b101011, 6'b010100: x = 5'd31;
            6'b001111, 6'b110000: begin
                x      = 5'd28;
                is_k28 = 1'b1;
            end
            default: v6 = 1'b0;
        endcase

        y_d = 3'd0;
        v4d = 1'b1;
        case (fghj)
            4'b1011, 4'b0100:                   y_d = 3'd0;
            4'b1001:                            y_d = 3'd1;
            4'b0101:                            y_d = 3'd2;
            4'b1100, 4'b0011:                   y_d = 3'd3;
            4'b1101, 4'b0010:                   y_d = 3'd4;
            4'b1010:                            y_d = 3'd5;
            4'b0110:                            y_d = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: y_d = 3'd7;
            default:                            v4d = 1'b0;
        endcase

        // K28 trailers are complemented relative to data; fold the RD+ form onto the RD- table.
        fghj_k = (abcdei == 6'b110000) ? ~fghj : fghj;
        y_k    = 3'd0;
        v4k    = 1'b1;
        case (fghj_k)
            4'b0100: y_k = 3'd0;
            4'b1001: y_k = 3'd1;
            4'b0101: y_k = 3'd2;
            4'b0011: y_k = 3'd3;
            4'b0010: y_k = 3'd4;
            4'b1010: y_k = 3'd5;
            4'b0110: y_k = 3'd6;
            4'b1000: y_k = 3'd7;
            default: v4k = 1'b0;
        endcase

        is_kx7 = v6 && !is_k28
                 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30)
                 && (fghj == 4'b0111 || fghj == 4'b1000);

        imb6_o = IMB_ZERO;
        if ($countones(abcdei) == 4)
            imb6_o = IMB_POS;
        else if ($countones(abcdei) == 2)
            imb6_o = IMB_NEG;

        imb4_o = IMB_ZERO;
        if ($countones(fghj) == 3)
            imb4_o = IMB_POS;
        else if ($countones(fghj) == 1)
            imb4_o = IMB_NEG;

        code_err_o = !v6 || (is_k28 ? !v4k : !v4d)
                     || (imb6_o == imb4_o && imb6_o != IMB_ZERO);

        byte_o = code_err_o ? EDB_BYTE : {(is_k28 ? y_k : y_d), x};
        k_o    = code_err_o || is_k28 || is_kx7;
    end

endmodule

// File: rtl/pcs_rx_decode_packer.sv
// PCS RX decode/pack: 8b/10b decode with running disparity, then PIPE word packing to 1/2/4 lanes.
// Optional RX_POLARITY_INV_EN adds RX_Polarity, which inverts Sym_In ahead of the decoder.
module pcs_rx_decode_packer
    import pcs_8b10b_pkg::*;
#(
    parameter int SYM_W     = 10,
    parameter int MAX_LANES = 4
) (
    input  logic                   PCLK,
    input  logic                   RST,
    input  logic [5:0]             DataBusWidth,
    input  logic [SYM_W-1:0]       Sym_In,
    input  logic                   Sym_Valid,
    input  logic                   Align_Lock,
`ifdef RX_POLARITY_INV_EN
    input  logic                   RX_Polarity,
`endif
    output logic [8*MAX_LANES-1:0] RX_Data,
    output logic [MAX_LANES-1:0]   RX_DataK,
    output logic [2:0]             RX_Status,
    output logic                   RX_Valid
);

    logic [SYM_W-1:0] sym_dec;
`ifdef RX_POLARITY_INV_EN
    assign sym_dec = RX_Polarity ? ~Sym_In : Sym_In;
`else
    assign sym_dec = Sym_In;
`endif

    logic [7:0] dec_byte;
    logic       dec_k;
    logic       dec_cerr;
    imb_t       imb6;
    imb_t       imb4;

    pcs_8b10b_dec_core u_dec (
        .sym_i      (sym_dec),
        .byte_o     (dec_byte),
        .k_o        (dec_k),
        .code_err_o (dec_cerr),
        .imb6_o     (imb6),
        .imb4_o     (imb4)
    );

    rd_t                   rd_q, rd_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [7:0]            s1_byte_q, s1_byte_d;
    logic                  s1_k_q, s1_k_d;
    logic                  s1_cerr_q, s1_cerr_d;
    logic                  s1_derr_q, s1_derr_d;
    logic                  sym_pos, sym_neg;

    logic [1:0]            lane_q, lane_d;
    logic [8*MAX_LANES-1:0] acc_q, acc_d;
    logic [MAX_LANES-1:0]  acck_q, acck_d;
    logic [2:0]            st_q, st_d;
    logic [5:0]            dbw_q, dbw_d;
    logic [8*MAX_LANES-1:0] rx_data_q, rx_data_d;
    logic [MAX_LANES-1:0]  rx_k_q, rx_k_d;
    logic [2:0]            rx_st_q, rx_st_d;
    logic                  rx_valid_q, rx_valid_d;

    logic [1:0]            n_m1;
    logic                  restart;
    logic [1:0]            lane_eff;
    logic [8*MAX_LANES-1:0] acc_n;
    logic [MAX_LANES-1:0]  k_n;
    logic [2:0]            sym_st;
    logic [2:0]            st_n;

    always_comb begin
        sym_pos = (imb6 == IMB_POS && imb4 == IMB_ZERO) || (imb6 == IMB_ZERO && imb4 == IMB_POS);
        sym_neg = (imb6 == IMB_NEG && imb4 == IMB_ZERO) || (imb6 == IMB_ZERO && imb4 == IMB_NEG);
        rd_d       = rd_q;
        s1_valid_d = 1'b0;
        s1_byte_d  = s1_byte_q;
        s1_k_d     = s1_k_q;
        s1_cerr_d  = s1_cerr_q;
        s1_derr_d  = s1_derr_q;
        if (!Align_Lock) begin
            rd_d = RD_NEG;
        end else if (Sym_Valid) begin
            s1_valid_d = 1'b1;
            s1_byte_d  = dec_byte;
            s1_k_d     = dec_k;
            s1_cerr_d  = dec_cerr;
            s1_derr_d  = 1'b0;
            // A wrong-polarity symbol is flagged but still resyncs RD to its own polarity.
            if (!dec_cerr) begin
                if (sym_pos) begin
                    s1_derr_d = (rd_q == RD_POS);
                    rd_d      = RD_POS;
                end else if (sym_neg) begin
                    s1_derr_d = (rd_q == RD_NEG);
                    rd_d      = RD_NEG;
                end
            end
        end
    end

    always_comb begin
        n_m1       = lanes_m1(DataBusWidth);
        dbw_d      = DataBusWidth;
        lane_d     = lane_q;
        acc_d      = acc_q;
        acck_d     = acck_q;
        st_d       = st_q;
        rx_data_d  = rx_data_q;
        rx_k_d     = rx_k_q;
        rx_st_d    = rx_st_q;
        rx_valid_d = 1'b0;
        restart    = 1'b0;
        lane_eff   = lane_q;
        acc_n      = acc_q;
        k_n        = acck_q;
        sym_st     = s1_cerr_q ? ST_DEC_ERR : (s1_derr_q ? ST_DISP_ERR : ST_OK);
        st_n       = st_q;

        if (!Align_Lock || (DataBusWidth != dbw_q && !s1_valid_q)) begin
            lane_d = 2'd0;
            acc_d  = '0;
            acck_d = '0;
            st_d   = ST_OK;
        end else if (s1_valid_q) begin
            // Width change or a mid-word comma discards the partial word and restarts at lane 0.
            restart  = (DataBusWidth != dbw_q) || (lane_q == 2'd0)
                       || (s1_k_q && s1_byte_q == K28_5_BYTE && n_m1 != 2'd0);
            lane_eff = restart ? 2'd0 : lane_q;
            acc_n    = restart ? '0 : acc_q;
            k_n      = restart ? '0 : acck_q;
            st_n     = status_merge(restart ? ST_OK : st_q, sym_st);
            acc_n[{lane_eff, 3'b000} +: 8] = s1_byte_q;
            k_n[lane_eff]                  = s1_k_q;
            if (lane_eff >= n_m1) begin
                rx_data_d  = acc_n;
                rx_k_d     = k_n;
                rx_st_d    = st_n;
                rx_valid_d = 1'b1;
                lane_d     = 2'd0;
                acc_d      = '0;
                acck_d     = '0;
                st_d       = ST_OK;
            end else begin
                lane_d = lane_eff + 2'd1;
                acc_d  = acc_n;
                acck_d = k_n;
                st_d   = st_n;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (RST) begin
            rd_q       <= RD_NEG;
            s1_valid_q <= 1'b0;
            s1_byte_q  <= '0;
            s1_k_q     <= 1'b0;
            s1_cerr_q  <= 1'b0;
            s1_derr_q  <= 1'b0;
            lane_q     <= '0;
            acc_q      <= '0;
            acck_q     <= '0;
            st_q       <= ST_OK;
            dbw_q      <= '0;
            rx_data_q  <= '0;
            rx_k_q     <= '0;
            rx_st_q    <= ST_OK;
            rx_valid_q <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            s1_valid_q <= s1_valid_d;
            s1_byte_q  <= s1_byte_d;
            s1_k_q     <= s1_k_d;
            s1_cerr_q  <= s1_cerr_d;
            s1_derr_q  <= s1_derr_d;
            lane_q     <= lane_d;
            acc_q      <= acc_d;
            acck_q     <= acck_d;
            st_q       <= st_d;
            dbw_q      <= dbw_d;
            rx_data_q  <= rx_data_d;
            rx_k_q     <= rx_k_d;
            rx_st_q    <= rx_st_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign RX_Data   = rx_data_q;
    assign RX_DataK  = rx_k_q;
    assign RX_Status = rx_st_q;
    assign RX_Valid  = rx_valid_q;

endmodule
